// File: rtl/mem_write_checker.sv
// Watches a processor's store bus and compares it against a small table of expected
// (address, data) writes, reporting pass, mismatch or timeout for each check run.
module mem_write_checker #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                NUM_CHK  = 4,
  parameter int                TIMEOUT  = 25,
  parameter bit                IGN_EN   = 1'b1,
  parameter logic [ADDR_W-1:0] IGN_ADDR = ADDR_W'(96),
  parameter bit                ORDERED  = 1'b1,
  parameter bit                STRICT   = 1'b1,
  localparam int               IDX_W    = (NUM_CHK > 1) ? $clog2(NUM_CHK) : 1,
  localparam int               CNT_W    = $clog2(NUM_CHK + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] DataAdr,
  input  logic [DATA_W-1:0] WriteData,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic              timeout,
  output logic [CNT_W-1:0]  match_cnt,
  output logic [ADDR_W-1:0] err_addr,
  output logic [DATA_W-1:0] err_data,
  output logic [15:0]       cyc_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} stateT;

  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT - 1);

  stateT               state_q, state_d;
  logic [ADDR_W-1:0]   tabAddr_q [NUM_CHK];
  logic [ADDR_W-1:0]   tabAddr_d [NUM_CHK];
  logic [DATA_W-1:0]   tabData_q [NUM_CHK];
  logic [DATA_W-1:0]   tabData_d [NUM_CHK];
  logic [NUM_CHK-1:0]  hit_q, hit_d;
  logic [CNT_W-1:0]    matchCnt_q, matchCnt_d;
  logic [15:0]         cycCnt_q, cycCnt_d;
  logic [ADDR_W-1:0]   errAddr_q, errAddr_d;
  logic [DATA_W-1:0]   errData_q, errData_d;
  logic                done_q, done_d, pass_q, pass_d, fail_q, fail_d, timeout_q, timeout_d;

  logic                storeValid, ordMatch, addrInTab, addrWrongData, unhitFound;
  logic                isMatch, isErr, clearRun;
  logic [NUM_CHK-1:0]  unhitSel;

  // Classify the current store against the table; unhitSel picks the lowest equal unhit entry.
  always_comb begin
    ordMatch      = 1'b0;
    addrInTab     = 1'b0;
    addrWrongData = 1'b0;
    unhitFound    = 1'b0;
    unhitSel      = '0;
    for (int i = 0; i < NUM_CHK; i++) begin
      if (tabAddr_q[i] == DataAdr) begin
        addrInTab = 1'b1;
        if (tabData_q[i] != WriteData) addrWrongData = 1'b1;
      end
      if (matchCnt_q == CNT_W'(i) && tabAddr_q[i] == DataAdr && tabData_q[i] == WriteData)
        ordMatch = 1'b1;
      if (!unhitFound && !hit_q[i] && tabAddr_q[i] == DataAdr && tabData_q[i] == WriteData) begin
        unhitFound  = 1'b1;
        unhitSel[i] = 1'b1;
      end
    end
    storeValid = MemWrite && !(IGN_EN && DataAdr == IGN_ADDR);
    isMatch    = 1'b0;
    isErr      = 1'b0;
    if (storeValid) begin
      if (ORDERED) begin
        if (ordMatch) isMatch = 1'b1;
        else if (addrInTab || STRICT) isErr = 1'b1;
      end else begin
        if (unhitFound) isMatch = 1'b1;
        else if (addrWrongData || STRICT) isErr = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    tabAddr_d  = tabAddr_q;
    tabData_d  = tabData_q;
    hit_d      = hit_q;
    matchCnt_d = matchCnt_q;
    cycCnt_d   = cycCnt_q;
    errAddr_d  = errAddr_q;
    errData_d  = errData_q;
    done_d     = done_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
    timeout_d  = timeout_q;
    clearRun   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cfg_we) begin
          for (int i = 0; i < NUM_CHK; i++) begin
            if (cfg_idx == IDX_W'(i)) begin
              tabAddr_d[i] = cfg_addr;
              tabData_d[i] = cfg_data;
            end
          end
        end
        clearRun = start;
      end
      RUN: begin
        if (cycCnt_q != 16'hFFFF) cycCnt_d = cycCnt_q + 16'd1;
        if (isMatch) begin
          matchCnt_d = matchCnt_q + CNT_W'(1);
          hit_d      = hit_q | unhitSel;
        end
        // A completing match wins over a same-cycle timeout; a mismatch reports as a mismatch.
        if (isMatch && matchCnt_q == CNT_W'(NUM_CHK - 1)) begin
          state_d = PASS;
          done_d  = 1'b1;
          pass_d  = 1'b1;
        end else if (isErr) begin
          state_d   = FAIL;
          done_d    = 1'b1;
          fail_d    = 1'b1;
          errAddr_d = DataAdr;
          errData_d = WriteData;
        end else if (cycCnt_q >= TO_LIMIT) begin
          state_d   = FAIL;
          done_d    = 1'b1;
          fail_d    = 1'b1;
          timeout_d = 1'b1;
        end
      end
      PASS, FAIL: clearRun = start;
    endcase
    if (clearRun) begin
      state_d    = RUN;
      hit_d      = '0;
      matchCnt_d = '0;
      cycCnt_d   = '0;
      errAddr_d  = '0;
      errData_d  = '0;
      done_d     = 1'b0;
      pass_d     = 1'b0;
      fail_d     = 1'b0;
      timeout_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      for (int i = 0; i < NUM_CHK; i++) begin
        tabAddr_q[i] <= '0;
        tabData_q[i] <= '0;
      end
      hit_q      <= '0;
      matchCnt_q <= '0;
      cycCnt_q   <= '0;
      errAddr_q  <= '0;
      errData_q  <= '0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tabAddr_q  <= tabAddr_d;
      tabData_q  <= tabData_d;
      hit_q      <= hit_d;
      matchCnt_q <= matchCnt_d;
      cycCnt_q   <= cycCnt_d;
      errAddr_q  <= errAddr_d;
      errData_q  <= errData_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      timeout_q  <= timeout_d;
    end
  end

  assign done      = done_q;
  assign pass      = pass_q;
  assign fail      = fail_q;
  assign timeout   = timeout_q;
  assign match_cnt = matchCnt_q;
  assign err_addr  = errAddr_q;
  assign err_data  = errData_q;
  assign cyc_cnt   = cycCnt_q;

endmodule

// File: tb/tb_mem_write_checker.sv
// Drives three checker variants (ordered/strict, unordered/strict, unordered/lenient)
// from one shared store bus and compares their verdicts against queued expectations.
module tb_mem_write_checker;

  localparam int T = 25;

  logic        clk = 1'b0;
  logic        reset, start, cfg_we, MemWrite;
  logic [1:0]  cfg_idx;
  logic [31:0] cfg_addr, cfg_data, DataAdr, WriteData;

  logic [2:0]        doneV, passV, failV, toV;
  logic [2:0][2:0]   mcV;
  logic [2:0][31:0]  eaV, edV;
  logic [2:0][15:0]  ccV;

  int checks = 0;
  int errors = 0;
  int tbCycle = 0;
  int startCycle = 0;

  typedef struct {
    string       tag;
    logic        done, pass, fail, to;
    logic [2:0]  mc;
    logic [31:0] ea, ed;
    logic [15:0] cyc;
  } expT;
  expT expQ[$];

  always #5 clk = ~clk;

  always @(posedge clk) tbCycle <= tbCycle + 1;

  mem_write_checker u0 (
    .clk(clk), .reset(reset), .start(start), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .MemWrite(MemWrite), .DataAdr(DataAdr),
    .WriteData(WriteData), .done(doneV[0]), .pass(passV[0]), .fail(failV[0]),
    .timeout(toV[0]), .match_cnt(mcV[0]), .err_addr(eaV[0]), .err_data(edV[0]),
    .cyc_cnt(ccV[0])
  );

  mem_write_checker #(.ORDERED(1'b0), .STRICT(1'b1)) u1 (
    .clk(clk), .reset(reset), .start(start), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .MemWrite(MemWrite), .DataAdr(DataAdr),
    .WriteData(WriteData), .done(doneV[1]), .pass(passV[1]), .fail(failV[1]),
    .timeout(toV[1]), .match_cnt(mcV[1]), .err_addr(eaV[1]), .err_data(edV[1]),
    .cyc_cnt(ccV[1])
  );

  mem_write_checker #(.ORDERED(1'b0), .STRICT(1'b0)) u2 (
    .clk(clk), .reset(reset), .start(start), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .MemWrite(MemWrite), .DataAdr(DataAdr),
    .WriteData(WriteData), .done(doneV[2]), .pass(passV[2]), .fail(failV[2]),
    .timeout(toV[2]), .match_cnt(mcV[2]), .err_addr(eaV[2]), .err_data(edV[2]),
    .cyc_cnt(ccV[2])
  );

  // Every comparison goes through here so the counters stay in one place.
  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pushExp(input string tag, input logic dn, input logic ps, input logic fl,
                         input logic to, input logic [2:0] mc, input logic [31:0] ea,
                         input logic [31:0] ed, input logic [15:0] cyc);
    expT e;
    e.tag = tag; e.done = dn; e.pass = ps; e.fail = fl; e.to = to;
    e.mc = mc; e.ea = ea; e.ed = ed; e.cyc = cyc;
    expQ.push_back(e);
  endtask

  // Pops the oldest expectation and compares it with the outputs of instance inst.
  task automatic checkOutput(input int inst);
    expT e;
    e = expQ.pop_front();
    checkVal({e.tag, ".done"},     doneV[inst], e.done);
    checkVal({e.tag, ".pass"},     passV[inst], e.pass);
    checkVal({e.tag, ".fail"},     failV[inst], e.fail);
    checkVal({e.tag, ".timeout"},  toV[inst],   e.to);
    checkVal({e.tag, ".matchCnt"}, mcV[inst],   e.mc);
    checkVal({e.tag, ".errAddr"},  eaV[inst],   e.ea);
    checkVal({e.tag, ".errData"},  edV[inst],   e.ed);
    checkVal({e.tag, ".cycCnt"},   ccV[inst],   e.cyc);
  endtask

  task automatic waitDone(input string tag, input int inst, input int budget);
    for (int i = 0; i < budget && !doneV[inst]; i++) @(negedge clk);
    checkVal({tag, ".reachedDone"}, doneV[inst], 1'b1);
  endtask

  task automatic resetDut();
    reset = 1'b0; start = 1'b0; cfg_we = 1'b0; MemWrite = 1'b0;
    cfg_idx = '0; cfg_addr = '0; cfg_data = '0; DataAdr = '0; WriteData = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic loadEntry(input logic [1:0] idx, input logic [31:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_idx = idx; cfg_addr = a; cfg_data = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic loadTable();
    loadEntry(2'd0, 32'd100, 32'd25);
    loadEntry(2'd1, 32'd104, 32'd7);
    loadEntry(2'd2, 32'd108, 32'd1);
    loadEntry(2'd3, 32'd112, 32'd0);
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    startCycle = tbCycle;
  endtask

  // One store on the bus, sampled at the next rising edge.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d);
    MemWrite = 1'b1; DataAdr = a; WriteData = d;
    @(negedge clk);
    MemWrite = 1'b0;
  endtask

  task automatic idleUntil(input int rel);
    while (tbCycle - startCycle < rel) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired before the summary");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    resetDut();
    for (int i = 0; i < 3; i++) begin
      pushExp("reset", 0, 0, 0, 0, 3'd0, 32'd0, 32'd0, 16'd0);
      checkOutput(i);
    end

    // In-order stores with ignored address 96 interleaved and a start pulse mid-run.
    loadTable();
    pulseStart();
    applyStimulus(32'd100, 32'd25);
    applyStimulus(32'd96, 32'hDEAD);
    start = 1'b1; @(negedge clk); start = 1'b0;
    applyStimulus(32'd104, 32'd7);
    applyStimulus(32'd96, 32'd1);
    applyStimulus(32'd108, 32'd1);
    applyStimulus(32'd112, 32'd0);
    waitDone("inorder", 0, 10);
    for (int i = 0; i < 3; i++) begin
      pushExp("inorder", 1, 1, 0, 0, 3'd4, 32'd0, 32'd0, 16'd7);
      checkOutput(i);
    end
    applyStimulus(32'd300, 32'd1);
    applyStimulus(32'd104, 32'd99);
    pushExp("inorderHold", 1, 1, 0, 0, 3'd4, 32'd0, 32'd0, 16'd7);
    checkOutput(0);

    // Ordered checker sees entry 1 first.
    resetDut();
    loadTable();
    pulseStart();
    applyStimulus(32'd96, 32'd3);
    applyStimulus(32'd104, 32'd7);
    waitDone("outOfOrder", 0, 10);
    pushExp("outOfOrder", 1, 0, 1, 0, 3'd0, 32'd104, 32'd7, 16'd2);
    checkOutput(0);

    // Reverse-ish order with a duplicate of an already-hit entry.
    resetDut();
    loadTable();
    pulseStart();
    applyStimulus(32'd112, 32'd0);
    applyStimulus(32'd108, 32'd1);
    applyStimulus(32'd100, 32'd25);
    applyStimulus(32'd100, 32'd25);
    applyStimulus(32'd104, 32'd7);
    waitDone("dupOrdered", 0, 10);
    pushExp("dupOrdered", 1, 0, 1, 0, 3'd0, 32'd112, 32'd0, 16'd1);
    checkOutput(0);
    waitDone("dupStrict", 1, 10);
    pushExp("dupStrict", 1, 0, 1, 0, 3'd3, 32'd100, 32'd25, 16'd4);
    checkOutput(1);
    waitDone("dupLenient", 2, 10);
    pushExp("dupLenient", 1, 1, 0, 0, 3'd4, 32'd0, 32'd0, 16'd5);
    checkOutput(2);

    // Unlisted address, then a listed address with wrong data.
    pulseStart();
    applyStimulus(32'd108, 32'd1);
    applyStimulus(32'd200, 32'd3);
    applyStimulus(32'd104, 32'd9);
    waitDone("badOrdered", 0, 10);
    pushExp("badOrdered", 1, 0, 1, 0, 3'd0, 32'd108, 32'd1, 16'd1);
    checkOutput(0);
    waitDone("badStrict", 1, 10);
    pushExp("badStrict", 1, 0, 1, 0, 3'd1, 32'd200, 32'd3, 16'd2);
    checkOutput(1);
    waitDone("badLenient", 2, 10);
    pushExp("badLenient", 1, 0, 1, 0, 3'd1, 32'd104, 32'd9, 16'd3);
    checkOutput(2);

    // Three of four matches, then silence until the timeout.
    pulseStart();
    applyStimulus(32'd100, 32'd25);
    applyStimulus(32'd104, 32'd7);
    applyStimulus(32'd108, 32'd1);
    waitDone("timeout", 0, 2 * T);
    checkVal("timeout.elapsed", 64'(tbCycle - startCycle), 64'(T));
    pushExp("timeout", 1, 0, 1, 1, 3'd3, 32'd0, 32'd0, 16'(T));
    checkOutput(0);
    pushExp("timeoutLenient", 1, 0, 1, 1, 3'd3, 32'd0, 32'd0, 16'(T));
    checkOutput(2);

    // Final match lands exactly on the timeout cycle.
    pulseStart();
    applyStimulus(32'd100, 32'd25);
    applyStimulus(32'd104, 32'd7);
    applyStimulus(32'd108, 32'd1);
    idleUntil(T - 1);
    applyStimulus(32'd112, 32'd0);
    waitDone("lastMatch", 0, 5);
    pushExp("lastMatch", 1, 1, 0, 0, 3'd4, 32'd0, 32'd0, 16'(T));
    checkOutput(0);

    // Mismatch on the timeout cycle reports as a mismatch.
    pulseStart();
    applyStimulus(32'd100, 32'd25);
    applyStimulus(32'd104, 32'd7);
    applyStimulus(32'd108, 32'd1);
    idleUntil(T - 1);
    applyStimulus(32'd112, 32'd5);
    waitDone("lastMismatch", 0, 5);
    pushExp("lastMismatch", 1, 0, 1, 0, 3'd3, 32'd112, 32'd5, 16'(T));
    checkOutput(0);

    // Table write attempted mid-run, proven harmless by a second run.
    pulseStart();
    applyStimulus(32'd100, 32'd25);
    applyStimulus(32'd104, 32'd7);
    loadEntry(2'd0, 32'd200, 32'd5);
    applyStimulus(32'd108, 32'd1);
    applyStimulus(32'd112, 32'd0);
    waitDone("cfgInRun", 0, 5);
    pushExp("cfgInRun", 1, 1, 0, 0, 3'd4, 32'd0, 32'd0, 16'd5);
    checkOutput(0);
    pulseStart();
    applyStimulus(32'd100, 32'd25);
    applyStimulus(32'd104, 32'd7);
    pushExp("rerunMid", 0, 0, 0, 0, 3'd2, 32'd0, 32'd0, 16'd2);
    checkOutput(0);

    // Asynchronous reset in the middle of that run.
    reset = 1'b0;
    #1;
    pushExp("midReset", 0, 0, 0, 0, 3'd0, 32'd0, 32'd0, 16'd0);
    checkOutput(0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    pulseStart();
    applyStimulus(32'd100, 32'd25);
    waitDone("clearedTable", 0, 5);
    pushExp("clearedTable", 1, 0, 1, 0, 3'd0, 32'd100, 32'd25, 16'd1);
    checkOutput(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
